dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Two-master arbiter sharing the single-port data memory (word array, byte enables).
//  Master 0: CPU M-stage data port. Master 1: secondary requester (DMA/debug loader).
//  Registered request/grant/response handshake; one access in flight; round-robin fairness.
//  Sits between the masters and the DM; the DM reads combinationally and writes on posedge clk.
// PARAMETERS
//  DEPTH_WORDS  4096  DM size in words; word index addr[31:2] >= DEPTH_WORDS is out of range
// PORTS
//  clk         in   1   clock
//  reset       in   1   sync, active-high
//  m0_req      in   1   master 0 request; hold with addr/wdata/byteen stable until m0_gnt
//  m0_addr     in   32  byte address
//  m0_wdata    in   32  write data, lanes already aligned to byteen
//  m0_byteen   in   4   0000 = read, else byte-lane write mask
//  m0_gnt      out  1   one-cycle pulse: request accepted and issued to DM this cycle
//  m0_rvalid   out  1   one-cycle pulse: access complete, m0_rdata valid
//  m0_rdata    out  32  word read (reads); pre-write word (writes); 0 if out of range
//  m0_err      out  1   with m0_rvalid: address out of range, nothing written
//  m1_*        --   --  identical set for master 1
//  mem_addr    out  32  word-aligned address to DM (addr & 32'hFFFF_FFFC)
//  mem_wdata   out  32  write data to DM
//  mem_byteen  out  4   DM byte write enables; nonzero only in ISSUE
//  mem_rdata   in   32  DM combinational read data
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, last=1 (master 0 wins first tie); all outputs 0 incl. m*_rdata.
//  States: IDLE, ISSUE, RESP. All outputs except mem_byteen are registered.
//  Arbitrate in IDLE and RESP over {m0_req,m1_req}: one requester wins; both -> the master
//   != last wins. Winner's addr/wdata/byteen and id latched at clock edge; last <= winner.
//  IDLE: any req -> ISSUE, else IDLE.
//  ISSUE (1 cycle): mem_* driven from latch; m<id>_gnt=1; mem_rdata captured at cycle end;
//   out of range -> mem_byteen forced 0000, capture 0, err flag set. -> RESP.
//  RESP (1 cycle): m<id>_rvalid=1, m<id>_rdata=captured word, m<id>_err=flag.
//   Any req (excl. served master's req only if sampled the gnt cycle; new req the
//   cycle after gnt is legal) -> ISSUE (back-to-back), else IDLE.
//  Latency: req sampled cycle N -> gnt N+1 -> rvalid N+2. Peak throughput 1 access / 2 cycles.
//  Masters must not drop req before gnt; behaviour undefined if they do.
//  Served master's req in the gnt cycle is a stale copy and is ignored by RESP arbitration.
//  Write data in DM visible to next access (posedge commit during ISSUE).
//  Simultaneous rvalid for one master and gnt for the other cannot occur (single in-flight).
//  mem_byteen = issue_byteen & {4{~reset}}: reset during ISSUE commits no write, aborts
//   access, no gnt/rvalid afterwards; all state cleared at the edge.
//  mem_addr/mem_wdata hold last issued values outside ISSUE (don't-care to DM).
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: fixed priority, master 0 always wins when both request;
//   last register unused (may starve m1 under continuous m0 traffic).
//  Undefined (default): round-robin as above; each master waits at most one foreign access.
// TESTING
//  Reset: after reset deassert, all outputs 0, busy=0, mem_byteen=0 for >=4 cycles.
//  m0 write addr 0x10 wdata 0xAABBCCDD byteen 1111 -> gnt N+1, mem_addr 0x10, rvalid N+2;
//   then m1 read 0x12 -> m1_rdata 0xAABBCCDD (aligned to 0x10), m1_err=0.
//  Byte write m0 addr 0x20 byteen 0100 wdata 0x00550000 onto word 0x11223344 -> read 0x11553344.
//  m0,m1 both req continuously from reset -> grants m0,m1,m0,m1, one access each 2 cycles;
//   with ARB_FIXED_PRIO_EN -> m0 granted every time, m1 never until m0_req drops.
//  m1 write addr 0x4000 (word 4096) byteen 1111 -> mem_byteen stays 0000, m1_rvalid with
//   m1_err=1, m1_rdata=0; word 0 unchanged.
//  reset asserted in ISSUE of m0 write 0x30 -> mem_byteen 0000 that cycle, word 0x30 unchanged,
//   no m0_rvalid; next m0 req after reset served normally.

Source files
------------

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_arbiter
//  Description : Two-master round-robin arbiter in front of the single-port
//                data memory; one registered access in flight at a time.
//                Define ARB_FIXED_PRIO_EN for fixed priority (master 0 wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_ISSUE = 2'd1;
    localparam logic [1:0]  c_ST_RESP  = 2'd2;
    localparam logic [30:0] c_DEPTH    = 31'(DEPTH_WORDS);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_id;
    logic [3:0]  r_byteen;
    logic        r_oor;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_m0_gnt, r_m0_rvalid, r_m0_err;
    logic        r_m1_gnt, r_m1_rvalid, r_m1_err;
    logic [31:0] r_m0_rdata, r_m1_rdata;
    logic        r_busy;

    logic        w_m0_sel;
    logic        w_m0_win;
    logic        w_m1_win;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_byteen;
    logic        w_sel_oor;

`ifdef ARB_FIXED_PRIO_EN
    always_comb w_m0_sel = m0_req;
`else
    logic r_last;

    // Master 0 wins a tie only when master 1 was the last one served.
    always_comb w_m0_sel = m0_req && (!m1_req || r_last);
`endif

    always_comb begin
        w_m0_win     = 1'b0;
        w_m1_win     = 1'b0;
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_RESP: begin
                if (m0_req || m1_req) begin
                    w_m0_win     = w_m0_sel;
                    w_m1_win     = !w_m0_sel;
                    w_state_next = c_ST_ISSUE;
                end else begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_ISSUE: w_state_next = c_ST_RESP;
            default:    w_state_next = c_ST_IDLE;
        endcase
        w_sel_addr   = w_m1_win ? m1_addr   : m0_addr;
        w_sel_wdata  = w_m1_win ? m1_wdata  : m0_wdata;
        w_sel_byteen = w_m1_win ? m1_byteen : m0_byteen;
        w_sel_oor    = ({1'b0, w_sel_addr[31:2]} >= c_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_id        <= 1'b0;
            r_byteen    <= 4'b0000;
            r_oor       <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_m0_gnt    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= 32'd0;
            r_m0_err    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= 32'd0;
            r_m1_err    <= 1'b0;
            r_busy      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            r_last      <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_next;
            r_busy      <= (w_state_next != c_ST_IDLE);
            r_m0_gnt    <= w_m0_win;
            r_m1_gnt    <= w_m1_win;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m1_err    <= 1'b0;
            if (w_m0_win || w_m1_win) begin
                r_id        <= w_m1_win;
                r_byteen    <= w_sel_byteen;
                r_oor       <= w_sel_oor;
                r_mem_addr  <= {w_sel_addr[31:2], 2'b00};
                r_mem_wdata <= w_sel_wdata;
`ifndef ARB_FIXED_PRIO_EN
                r_last      <= w_m1_win;
`endif
            end
            // Capture the pre-write word at the end of the issue cycle.
            if (r_state == c_ST_ISSUE) begin
                if (r_id) begin
                    r_m1_rvalid <= 1'b1;
                    r_m1_rdata  <= r_oor ? 32'd0 : mem_rdata;
                    r_m1_err    <= r_oor;
                end else begin
                    r_m0_rvalid <= 1'b1;
                    r_m0_rdata  <= r_oor ? 32'd0 : mem_rdata;
                    r_m0_err    <= r_oor;
                end
            end
        end
    end

    // Gated by reset so an access aborted mid-issue never commits.
    assign mem_byteen = ((r_state == c_ST_ISSUE) && !r_oor) ? (r_byteen & {4{~reset}}) : 4'b0000;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign m0_gnt     = r_m0_gnt;
    assign m0_rvalid  = r_m0_rvalid;
    assign m0_rdata   = r_m0_rdata;
    assign m0_err     = r_m0_err;
    assign m1_gnt     = r_m1_gnt;
    assign m1_rvalid  = r_m1_rvalid;
    assign m1_rdata   = r_m1_rdata;
    assign m1_err     = r_m1_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_arbiter
//  Description : Directed self-checking bench for dm_arbiter with a
//                behavioural data memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;
    logic        busy;
    logic        r_mem_clear;
    logic [31:0] r_mem [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.DEPTH_WORDS(4096)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Index truncation is deliberate: an unguarded out-of-range access aliases onto low words.
    assign mem_rdata = r_mem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (r_mem_clear) begin
            for (int i = 0; i < 4096; i++) r_mem[i] <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_byteen[b]) r_mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Drives one request and reports what was observed; latencies are -1 on timeout.
    task automatic access(input bit id, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int gl, output int rl,
                          output logic [31:0] maddr, output logic [3:0] mbe,
                          output logic [31:0] rd, output logic er);
        gl = -1; rl = -1; maddr = 32'd0; mbe = 4'd0; rd = 32'd0; er = 1'b0;
        if (id) begin m1_req = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_byteen = be; end
        else    begin m0_req = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_byteen = be; end
        for (int c = 1; c <= 10 && rl < 0; c++) begin
            @(posedge clk); #1;
            if (gl < 0 && (id ? m1_gnt : m0_gnt)) begin
                gl = c; maddr = mem_addr; mbe = mem_byteen;
                if (id) m1_req = 1'b0; else m0_req = 1'b0;
            end
            if (id ? m1_rvalid : m0_rvalid) begin
                rl = c; rd = id ? m1_rdata : m0_rdata; er = id ? m1_err : m0_err;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; r_mem_clear = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; r_mem_clear = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
                 mem_addr, mem_wdata, mem_byteen, busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: busy=%b byteen=%b m0_rdata=%h m1_rdata=%h mem_addr=%h, required all zero",
                         c, busy, mem_byteen, m0_rdata, m1_rdata, mem_addr);
            end
        end
    endtask

    task automatic test_write_read();
        int gl, rl; logic [31:0] ma, rd; logic [3:0] mb; logic er;
        access(1'b0, 32'h10, 32'hAABBCCDD, 4'hF, gl, rl, ma, mb, rd, er);
        checks++; if (gl !== 1) begin errors++; $display("FAIL wr_gnt_latency got %0d required 1", gl); end
        checks++; if (rl !== 2) begin errors++; $display("FAIL wr_rvalid_latency got %0d required 2", rl); end
        checks++; if (ma !== 32'h10) begin errors++; $display("FAIL wr_mem_addr got %h required 00000010", ma); end
        checks++; if (mb !== 4'hF) begin errors++; $display("FAIL wr_mem_byteen got %b required 1111", mb); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_prewrite_rdata got %h required 00000000", rd); end
        access(1'b1, 32'h12, 32'h0, 4'h0, gl, rl, ma, mb, rd, er);
        checks++; if (ma !== 32'h10) begin errors++; $display("FAIL rd_mem_addr_aligned got %h required 00000010", ma); end
        checks++; if (mb !== 4'h0) begin errors++; $display("FAIL rd_mem_byteen got %b required 0000", mb); end
        checks++; if (rd !== 32'hAABBCCDD) begin errors++; $display("FAIL m1_read_rdata got %h required aabbccdd", rd); end
        checks++; if (er !== 1'b0 || rl !== 2) begin errors++; $display("FAIL m1_read_err_latency got err=%b lat=%0d required err=0 lat=2", er, rl); end
    endtask

    task automatic test_byte_write();
        int gl, rl; logic [31:0] ma, rd; logic [3:0] mb; logic er;
        access(1'b0, 32'h20, 32'h11223344, 4'hF, gl, rl, ma, mb, rd, er);
        access(1'b0, 32'h20, 32'h00550000, 4'b0100, gl, rl, ma, mb, rd, er);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL byte_prewrite got %h required 11223344", rd); end
        checks++; if (mb !== 4'b0100) begin errors++; $display("FAIL byte_mem_byteen got %b required 0100", mb); end
        access(1'b0, 32'h20, 32'h0, 4'h0, gl, rl, ma, mb, rd, er);
        checks++; if (rd !== 32'h11553344) begin errors++; $display("FAIL byte_merged got %h required 11553344", rd); end
    endtask

    task automatic test_out_of_range();
        int gl, rl; logic [31:0] ma, rd; logic [3:0] mb; logic er;
        access(1'b0, 32'h0, 32'hCAFEF00D, 4'hF, gl, rl, ma, mb, rd, er);
        access(1'b1, 32'h4000, 32'hDEADBEEF, 4'hF, gl, rl, ma, mb, rd, er);
        checks++; if (mb !== 4'h0) begin errors++; $display("FAIL oor_mem_byteen got %b required 0000", mb); end
        checks++; if (er !== 1'b1 || rl !== 2) begin errors++; $display("FAIL oor_err got err=%b lat=%0d required err=1 lat=2", er, rl); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h required 00000000", rd); end
        access(1'b0, 32'h0, 32'h0, 4'h0, gl, rl, ma, mb, rd, er);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL oor_word0_intact got %h err=%b required cafef00d err=0", rd, er); end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_g;
        reset = 1'b1;
        @(posedge clk); #1;
        m0_req = 1'b1; m0_addr = 32'h0; m0_byteen = 4'h0;
        m1_req = 1'b1; m1_addr = 32'h4; m1_byteen = 4'h0;
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
`ifdef ARB_FIXED_PRIO_EN
            exp_g = (c == 9) ? 2'b01 : ((c % 2) == 1) ? 2'b10 : 2'b00;
`else
            exp_g = (c == 9) ? 2'b01 : ((c % 4) == 1) ? 2'b10 : ((c % 4) == 3) ? 2'b01 : 2'b00;
`endif
            checks++;
            if ({m0_gnt, m1_gnt} !== exp_g) begin
                errors++;
                $display("FAIL arb_grant cycle %0d got {m0,m1}=%b required %b", c, {m0_gnt, m1_gnt}, exp_g);
            end
            if (c == 8) m0_req = 1'b0;
            if (c == 9) m1_req = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle_busy got %b required 0", busy); end
    endtask

    task automatic test_reset_in_issue();
        int gl, rl; logic [31:0] ma, rd; logic [3:0] mb; logic er;
        access(1'b0, 32'h30, 32'h01020304, 4'hF, gl, rl, ma, mb, rd, er);
        m0_req = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h77777777; m0_byteen = 4'hF;
        @(posedge clk); #1;
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rst_issue_gnt got %b required 1", m0_gnt); end
        reset = 1'b1;
        #1;
        checks++; if (mem_byteen !== 4'h0) begin errors++; $display("FAIL rst_issue_byteen got %b required 0000", mem_byteen); end
        @(posedge clk); #1;
        reset = 1'b0; m0_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rst_no_rvalid cycle %0d got %b required 0", c, m0_rvalid); end
            @(posedge clk); #1;
        end
        access(1'b0, 32'h30, 32'h0, 4'h0, gl, rl, ma, mb, rd, er);
        checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL rst_word_unchanged got %h required 01020304", rd); end
        checks++; if (gl !== 1 || rl !== 2) begin errors++; $display("FAIL rst_recovery_latency got gnt=%0d rvalid=%0d required 1 and 2", gl, rl); end
    endtask

    initial begin
        reset = 1'b1; r_mem_clear = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_out_of_range();
        test_arbitration();
        test_reset_in_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
